fifo_uart_tx: RTL and testbench

Byte serializer that drains the 8-bit, 32-deep synchronous FIFO and transmits each byte as an asynchronous serial frame (start, 8 data LSB-first, optional parity, stop). It sits directly downstream of the FIFO. It issues single-cycle read strobes when the FIFO is non-empty and captures the FIFO's registered read data one cycle later. It is the only reader of that FIFO.

---
 rtl/fifo_uart_tx_if.sv | 32 +++
 rtl/fifo_uart_tx.sv | 155 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO-draining UART transmitter and its environment.
// master: the transmitter (issues read strobes, drives the serial line).
// slave:  the environment (FIFO flags/data, enable, line observer).
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read synchronous FIFO one byte at a time and serialises each byte as
// start, 8 data bits LSB-first, optional parity, stop. tx and frame_done are registered from
// the next-state values so they line up exactly with the state they belong to.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned      BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           r_state;
  logic [BaudW-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_frame_done;

  state_e           w_state_next;
  logic [BaudW-1:0] w_baud_next;
  logic [2:0]       w_bit_next;
  logic [7:0]       w_shift_next;
  logic             w_parity_next;
  logic             w_tx_next;
  logic             w_frame_done_next;
  logic             w_bit_end;

  assign w_bit_end = (r_baud == BaudLast);

  // State, counters, datapath and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_baud       <= w_baud_next;
      r_bit_idx    <= w_bit_next;
      r_shift      <= w_shift_next;
      r_parity     <= w_parity_next;
      r_tx         <= w_tx_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // Next-state, baud/bit counting, byte capture and parity accumulation.
  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    unique case (r_state)
      StIdle: begin
        w_baud_next = '0;
        // fifo_empty is only trusted here: as sole reader, the FIFO cannot drain before POP.
        if (bus.tx_en && !bus.fifo_empty) begin
          w_state_next = StPop;
        end
      end
      StPop: begin
        w_state_next = StLoad;
      end
      StLoad: begin
        // Registered FIFO read data is valid the cycle after the strobe.
        w_shift_next  = bus.fifo_data;
        w_parity_next = 1'b0;
        w_baud_next   = '0;
        w_state_next  = StStart;
      end
      StStart: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = StData;
        end else begin
          w_baud_next = r_baud + BaudW'(1);
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_next   = '0;
          w_shift_next  = {1'b0, r_shift[7:1]};
          // Fold in the bit that just finished on the line.
          w_parity_next = r_parity ^ r_shift[0];
          if (r_bit_idx == 3'd7) begin
            w_state_next = PARITY_EN ? StParity : StStop;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BaudW'(1);
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = StStop;
        end else begin
          w_baud_next = r_baud + BaudW'(1);
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = StIdle;
        end else begin
          w_baud_next = r_baud + BaudW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Line level and done pulse for the coming cycle, derived from the next state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      StStart:  w_tx_next = 1'b0;
      StData:   w_tx_next = w_shift_next[0];
      StParity: w_tx_next = w_parity_next ^ PARITY_ODD;
      default:  w_tx_next = 1'b1;
    endcase
    w_frame_done_next = (w_state_next == StStop) && (w_baud_next == BaudLast);
  end

  assign bus.fifo_rd_en = (r_state == StPop);
  assign bus.busy       = (r_state != StIdle);
  assign bus.tx         = r_tx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even parity, odd parity) at 4 clocks
// per bit, each fed by a queue-based FIFO model. Bytes pushed by the stimulus go into an
// expected queue; a line monitor per instance rebuilds frames from the serial line and checks
// them against that queue. Directed sections add cycle-exact latency and gating checks.
module tb_fifo_uart_tx;

  localparam int Cpb   = 4;
  localparam int NEnv  = 3;
  localparam int KTx   = 0;
  localparam int KRd   = 1;
  localparam int KFd   = 2;
  localparam int KBusy = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic [2:0] tx_en_v   = 3'b000;
  logic [2:0] push_mask = 3'b000;
  logic [7:0] push_byte = 8'h00;

  wire [2:0]  tx_v;
  wire [2:0]  rd_v;
  wire [2:0]  busy_v;
  wire [2:0]  fd_v;
  wire [2:0]  rd_err_v;
  wire [31:0] rd_cnt_v [NEnv];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         push_cnt [NEnv] = '{default: 0};
  logic [7:0] exp_q [NEnv][$];
  bit         mon_act [NEnv] = '{default: 1'b0};
  logic       rec [4][200];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NEnv; g++) begin : g_env
    fifo_uart_tx_if bus ();
    logic [7:0] fq [$];
    logic [7:0] data_q  = 8'h00;
    logic       empty_q = 1'b1;
    logic       rd_err  = 1'b0;
    int         rd_cnt  = 0;

    assign bus.tx_en      = tx_en_v[g];
    assign bus.fifo_data  = data_q;
    assign bus.fifo_empty = empty_q;
    assign tx_v[g]        = bus.tx;
    assign rd_v[g]        = bus.fifo_rd_en;
    assign busy_v[g]      = bus.busy;
    assign fd_v[g]        = bus.frame_done;
    assign rd_err_v[g]    = rd_err;
    assign rd_cnt_v[g]    = rd_cnt;

    fifo_uart_tx #(
      .CLKS_PER_BIT (Cpb),
      .PARITY_EN    (g > 0),
      .PARITY_ODD   (g == 2)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // FIFO model: registered read data and a registered empty flag.
    always @(posedge clk) begin
      if (push_mask[g]) fq.push_back(push_byte);
      if (bus.fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (fq.size() == 0) rd_err <= 1'b1;
        else data_q <= fq.pop_front();
      end
      empty_q <= (fq.size() == 0);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Required line level in bit slot k of a frame carrying byte b on instance g.
  function automatic logic line_bit(input int g, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (g > 0 && k == 9) return (^b) ^ (g == 2);
    return 1'b1;
  endfunction

  task automatic monitor(input int g);
    int         t;
    int         last;
    logic [7:0] b;
    logic       lv;
    bit         bad;
    bit         done_bad;
    t = 0;
    b = 8'h00;
    bad = 1'b0;
    done_bad = 1'b0;
    last = ((g == 0) ? 10 : 11) * Cpb - 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        // Frame cut short by reset: its byte is discarded.
        mon_act[g] = 1'b0;
        continue;
      end
      if (!mon_act[g]) begin
        if (fd_v[g] === 1'b1) begin
          n_tests++;
          n_fail++;
          $display("FAIL stray_frame_done env%0d: got 1, required 0", g);
        end
        if (tx_v[g] === 1'b0) begin
          mon_act[g] = 1'b1;
          t = 0;
          bad = 1'b0;
          done_bad = 1'b0;
          if (exp_q[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame env%0d: got a start bit, required none", g);
            b = 8'h00;
          end else begin
            b = exp_q[g].pop_front();
          end
        end
      end
      if (mon_act[g]) begin
        lv = line_bit(g, b, t / Cpb);
        if (tx_v[g] !== lv && !bad) begin
          bad = 1'b1;
          $display("FAIL frame_line env%0d byte %h t=%0d: got %b, required %b",
                   g, b, t, tx_v[g], lv);
        end
        if (fd_v[g] !== (t == last) && !done_bad) begin
          done_bad = 1'b1;
          $display("FAIL frame_done_pos env%0d byte %h t=%0d: got %b, required %b",
                   g, b, t, fd_v[g], (t == last));
        end
        if (t == last) begin
          n_tests += 2;
          n_fail  += int'(bad) + int'(done_bad);
          mon_act[g] = 1'b0;
        end else begin
          t++;
        end
      end
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [7:0] b);
    @(negedge clk);
    push_mask = m;
    push_byte = b;
    for (int g = 0; g < NEnv; g++) begin
      if (m[g]) begin
        exp_q[g].push_back(b);
        push_cnt[g]++;
      end
    end
    @(posedge clk);
    #1 push_mask = 3'b000;
  endtask

  // Record outputs of instance g for cycles 1..n, sampled at each negedge.
  task automatic observe(input int g, input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      rec[KTx][c]   = tx_v[g];
      rec[KRd][c]   = rd_v[g];
      rec[KFd][c]   = fd_v[g];
      rec[KBusy][c] = busy_v[g];
    end
  endtask

  function automatic int find(input int kind, input int from, input int to, input logic val);
    for (int c = from; c <= to; c++) if (rec[kind][c] === val) return c;
    return -1;
  endfunction

  function automatic int count(input int kind, input int from, input int to, input logic val);
    int n;
    n = 0;
    for (int c = from; c <= to; c++) if (rec[kind][c] === val) n++;
    return n;
  endfunction

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (busy_v == 3'b000) && !mon_act[0] && !mon_act[1] && !mon_act[2] &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0;
    end
    check(name, int'(done), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mism;
    int          fd1;
    int          st;
    logic [9:0]  a5_slots;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset held with a non-empty FIFO and permission to send.
    rst = 1'b0;
    tx_en_v = 3'b111;
    push(3'b111, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {tx_v, rd_v, busy_v, fd_v}, 12'hE00);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drain("drain_after_reset", 300);
    tx_en_v = 3'b000;

    // Single byte 0xA5: latency, line pattern, done pulse and busy.
    push(3'b001, 8'hA5);
    @(negedge clk);
    tx_en_v[0] = 1'b1;
    observe(0, 50);
    a5_slots = 10'b1101001010;
    mism = 0;
    for (int c = 3; c <= 42; c++) if (rec[KTx][c] !== a5_slots[(c - 3) / 4]) mism++;
    check("a5_rd_count", count(KRd, 1, 50, 1'b1), 1);
    check("a5_rd_cycle", find(KRd, 1, 50, 1'b1), 1);
    check("a5_start_cycle", find(KTx, 1, 50, 1'b0), 3);
    check("a5_tx_pattern_mismatches", mism, 0);
    check("a5_frame_done_cycle", find(KFd, 1, 50, 1'b1), 42);
    check("a5_frame_done_count", count(KFd, 1, 50, 1'b1), 1);
    check("a5_busy_last_stop", int'(rec[KBusy][42]), 1);
    check("a5_busy_after", int'(rec[KBusy][43]), 0);

    // Back-to-back 0x00 then 0xFF.
    tx_en_v[0] = 1'b0;
    push(3'b001, 8'h00);
    push(3'b001, 8'hFF);
    @(negedge clk);
    tx_en_v[0] = 1'b1;
    observe(0, 100);
    fd1 = find(KFd, 1, 100, 1'b1);
    check("b2b_rd_gap", find(KRd, 2, 100, 1'b1) - fd1, 2);
    check("b2b_start_gap", find(KTx, fd1 + 1, 100, 1'b0) - fd1, 4);
    check("b2b_rd_count", count(KRd, 1, 100, 1'b1), 2);
    check("b2b_frame_done_count", count(KFd, 1, 100, 1'b1), 2);

    // Parity on 0x07: even sense gives 1, odd sense gives 0; 44-cycle frames.
    push(3'b110, 8'h07);
    for (int g = 1; g <= 2; g++) begin
      @(negedge clk);
      tx_en_v[g] = 1'b1;
      observe(g, 50);
      st = find(KTx, 1, 50, 1'b0);
      check("parity_start_cycle", st, 3);
      check("parity_bit_value", int'(rec[KTx][40]), (g == 1) ? 1 : 0);
      check("parity_frame_length", find(KFd, 1, 50, 1'b1) - st + 1, 44);
    end

    // Empty FIFO with permission: no strobe, line idle.
    observe(0, 50);
    check("empty_rd_count", count(KRd, 1, 50, 1'b1), 0);
    check("empty_tx_low_cycles", count(KTx, 1, 50, 1'b0), 0);

    // Permission dropped mid-frame with two bytes queued.
    tx_en_v[0] = 1'b0;
    push(3'b001, 8'h5A);
    push(3'b001, 8'hC3);
    @(negedge clk);
    tx_en_v[0] = 1'b1;
    fork
      observe(0, 120);
      begin
        repeat (10) @(negedge clk);
        tx_en_v[0] = 1'b0;
      end
    join
    check("gate_rd_count", count(KRd, 1, 120, 1'b1), 1);
    check("gate_frame_done_count", count(KFd, 1, 120, 1'b1), 1);
    check("gate_idle_at_end", int'(rec[KBusy][120]), 0);
    @(negedge clk);
    tx_en_v[0] = 1'b1;
    observe(0, 60);
    check("gate_resume_rd_cycle", find(KRd, 1, 60, 1'b1), 1);

    // Reset during data bit 3 of 0x96; 0x4B must follow cleanly afterwards.
    tx_en_v[0] = 1'b0;
    push(3'b001, 8'h96);
    push(3'b001, 8'h4B);
    @(negedge clk);
    tx_en_v[0] = 1'b1;
    observe(0, 20);
    check("rst_mid_bit3_level", int'(rec[KTx][20]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {tx_v[0], busy_v[0], fd_v[0]}, 3'b100);
    @(posedge clk);
    #1 rst = 1'b1;
    observe(0, 60);
    check("rst_mid_next_rd_cycle", find(KRd, 1, 60, 1'b1), 2);
    check("rst_mid_next_frame_done", count(KFd, 1, 60, 1'b1), 1);

    // Random traffic with random permission toggling.
    for (int i = 0; i < 40; i++) begin
      push(3'($urandom_range(1, 7)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) tx_en_v = 3'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    tx_en_v = 3'b111;
    drain("random_drain", 6000);

    for (int g = 0; g < NEnv; g++) begin
      check("reads_vs_pushes", int'(rd_cnt_v[g]), push_cnt[g]);
      check("read_on_empty", int'(rd_err_v[g]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
